// File: rtl/memory_round_ctrl_pkg.sv
// Shared types and defaults for the memory game round controller.
// Holds the FSM state encoding, key width and show-length helper.
package game_pkg;

  localparam int unsigned KEY_W = 4;

  localparam int unsigned DEF_SHOW_CYCLES   = 32'd500_000_000;
  localparam int unsigned DEF_SHOW_DEC      = 32'd50_000_000;
  localparam int unsigned DEF_MIN_SHOW      = 32'd100_000_000;
  localparam int unsigned DEF_INPUT_TIMEOUT = 32'd1_000_000_000;
  localparam int unsigned DEF_MAX_LEVEL     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LATCH,
    ST_SHOW,
    ST_INPUT,
    ST_CHECK,
    ST_FAIL,
    ST_WIN
  } state_e;

  // Show length shrinks per level but never drops below the floor; the
  // reduction is checked against the base first so the subtract cannot wrap.
  function automatic logic [31:0] show_len(input logic [31:0] lvl,
                                           input logic [31:0] base,
                                           input logic [31:0] dec,
                                           input logic [31:0] floor_len);
    logic [31:0] red;
    red = lvl * dec;
    if (red >= base || (base - red) < floor_len) return floor_len;
    return base - red;
  endfunction

endpackage

// File: rtl/memory_round_ctrl_phase_timer.sv
// Loadable 32-bit down counter; done is high while the count is zero.
// Used for both the show phase and the input idle window.
module phase_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        dec_i,
  output logic        done_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)              cnt_q <= '0;
    else if (load_i)                 cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_q <= cnt_q - 32'd1;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/memory_round_ctrl.sv
// Multi-level round controller for the keypad memorization game.
// Optional MEMORY_BACKSPACE_EN makes BACKSPACE_CODE delete the last digit.
module memory_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SHOW_CYCLES    = DEF_SHOW_CYCLES,
  parameter int unsigned SHOW_DEC       = DEF_SHOW_DEC,
  parameter int unsigned MIN_SHOW       = DEF_MIN_SHOW,
  parameter int unsigned INPUT_TIMEOUT  = DEF_INPUT_TIMEOUT,
  parameter int unsigned MAX_LEVEL      = DEF_MAX_LEVEL,
  parameter logic [3:0]  BACKSPACE_CODE = 4'hE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [4*DIGITS-1:0]            target,
  input  logic                           key_valid,
  input  logic [3:0]                     key_value,
  output logic                           new_target,
  output logic                           show,
  output logic [4*DIGITS-1:0]            entry,
  output logic [$clog2(DIGITS+1)-1:0]    entry_count,
  output logic                           pass,
  output logic                           fail,
  output logic                           win,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level,
  output logic                           busy
);

  localparam int unsigned EW = KEY_W * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned LW = $clog2(MAX_LEVEL + 1);
  localparam logic [CW-1:0] DIG_C    = CW'(DIGITS);
  localparam logic [LW-1:0] LAST_LVL = LW'(MAX_LEVEL - 1);

`ifdef MEMORY_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  state_e        state_q;
  logic [EW-1:0] target_q, entry_q;
  logic [CW-1:0] cnt_q;
  logic [LW-1:0] level_q;
  logic          new_target_q, show_q, pass_q, fail_q, win_q, busy_q;

  logic          is_bs, show_done, idle_done, tmr_clr;
  logic [31:0]   show_ld_val;

  assign is_bs       = BS_EN && (key_value == BACKSPACE_CODE);
  assign tmr_clr     = (state_q == ST_IDLE) || (state_q == ST_FAIL) || (state_q == ST_WIN);
  assign show_ld_val = show_len(32'(level_q), SHOW_CYCLES, SHOW_DEC, MIN_SHOW) - 32'd1;

  phase_timer u_show_tmr (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (tmr_clr),
    .load_i     (state_q == ST_LATCH),
    .load_val_i (show_ld_val),
    .dec_i      (state_q == ST_SHOW),
    .done_o     (show_done)
  );

  // Reloaded on entry to INPUT and on every key, so it measures idle time only.
  phase_timer u_idle_tmr (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (tmr_clr),
    .load_i     ((state_q == ST_SHOW && show_done) || (state_q == ST_INPUT && key_valid)),
    .load_val_i (32'(INPUT_TIMEOUT - 1)),
    .dec_i      (state_q == ST_INPUT),
    .done_o     (idle_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      entry_q      <= '0;
      cnt_q        <= '0;
      level_q      <= '0;
      new_target_q <= 1'b0;
      show_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      win_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      new_target_q <= 1'b0;
      pass_q       <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          state_q      <= ST_LOAD;
          new_target_q <= 1'b1;
          busy_q       <= 1'b1;
        end
        ST_LOAD: state_q <= ST_LATCH;
        ST_LATCH: begin
          target_q <= target;
          entry_q  <= '0;
          cnt_q    <= '0;
          show_q   <= 1'b1;
          state_q  <= ST_SHOW;
        end
        ST_SHOW: if (show_done) begin
          show_q  <= 1'b0;
          state_q <= ST_INPUT;
        end
        ST_INPUT: begin
          if (cnt_q == DIG_C) begin
            state_q <= ST_CHECK;
          end else if (key_valid) begin
            if (is_bs) begin
              if (cnt_q != '0) begin
                entry_q <= entry_q >> KEY_W;
                cnt_q   <= cnt_q - CW'(1);
              end
            end else begin
              entry_q <= {entry_q[EW-KEY_W-1:0], key_value};
              cnt_q   <= cnt_q + CW'(1);
            end
          end else if (idle_done) begin
            state_q <= ST_FAIL;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (entry_q == target_q) begin
            pass_q <= 1'b1;
            if (level_q == LAST_LVL) begin
              state_q <= ST_WIN;
              win_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              level_q      <= level_q + LW'(1);
              state_q      <= ST_LOAD;
              new_target_q <= 1'b1;
            end
          end else begin
            state_q <= ST_FAIL;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_FAIL, ST_WIN: if (start) begin
          level_q      <= '0;
          fail_q       <= 1'b0;
          win_q        <= 1'b0;
          state_q      <= ST_LOAD;
          new_target_q <= 1'b1;
          busy_q       <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign new_target  = new_target_q;
  assign show        = show_q;
  assign entry       = entry_q;
  assign entry_count = cnt_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign win         = win_q;
  assign level       = level_q;
  assign busy        = busy_q;

endmodule
